uart_param_tx: RTL and testbench
================================

// Module: uart_param_tx
// PURPOSE
//  Runtime-configurable UART transmitter; parametrised successor of the fixed 8-bit UART config.
//  Serialises one word per valid/ready handshake into start, 5..MAX_DATA_WIDTH data bits (LSB first),
//  optional even/odd parity and 1/2 stop bits. Uses 16x/13x oversampling off a clock divisor.
//  Sits between the Tx driver/BFM and the serial line.
// PARAMETERS
//  MAX_DATA_WIDTH  8   widest data field supported; tx_data width (>=5)
//  DIV_WIDTH       16  width of cfg_baud_div (clk cycles per oversample tick)
// PORTS
//  clk             in   1               single clock, all logic rising-edge
//  rst_n           in   1               synchronous, active-low reset
//  cfg_data_bits   in   4               data bits per frame (5..MAX_DATA_WIDTH)
//  cfg_parity_en   in   1               1 = parity bit present
//  cfg_parity_odd  in   1               0 = even, 1 = odd parity
//  cfg_two_stop    in   1               0 = one stop bit, 1 = two
//  cfg_os13        in   1               0 = 16x, 1 = 13x oversampling
//  cfg_baud_div    in   DIV_WIDTH       clk cycles per oversample tick
//  tx_valid        in   1               word available
//  tx_data         in   MAX_DATA_WIDTH  word; only low cfg_data_bits bits used
//  tx_ready        out  1               block can accept a word
//  tx_out          out  1               serial line, idle high
//  tx_busy         out  1               frame in progress
//  frame_done      out  1               1-cycle pulse, last clk of final stop bit
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): state IDLE, tx_out=1, tx_busy=0, frame_done=0, counters 0.
//    tx_ready is gated 0 while rst_n low. Reset mid-frame aborts: no frame_done, line high next edge.
//  - Handshake: accept when tx_valid && tx_ready. tx_ready = 1 only in IDLE.
//    tx_data and all cfg_* are latched at accept. Config changes mid-frame have no effect.
//  - FSM: IDLE -> START -> DATA -> [PARITY if parity_en] -> STOP (1 or 2 bits) -> IDLE.
//  - Latency: tx_out drives 0 (start) and tx_busy=1 on the clk after accept.
//  - Bit period = div_eff * OS clks. OS = 16 or 13. div_eff = cfg_baud_div, with 0 treated as 1.
//    Tick counter wraps at div_eff-1. Oversample counter wraps at OS-1; wrap advances the bit.
//  - Data bits: latched width clamped: <5 -> 5, >MAX_DATA_WIDTH -> MAX_DATA_WIDTH.
//    Bits shifted LSB first.
//  - Parity = XOR of the used (masked) data bits; inverted when parity_odd.
//  - frame_done pulses in the last clk of the last stop bit. Next clk: IDLE, tx_busy=0, tx_ready=1.
//    Back-to-back frames therefore have exactly 1 idle-high clk between stop and next start.
//  - tx_valid while busy is ignored (held by source); tx_data may change freely when not accepted.
// CONFIGURATION
//  UART_TX_PARITY_ERR_INJ_EN defined: extra port cfg_parity_inj (in, 1), latched at accept.
//    When 1 and parity enabled, the transmitted parity bit is inverted. Used for parity-error testing.
//  Undefined: port absent; parity always correct.
// TESTING
//  1. 8N1, OS16, div=1, 0x55 -> start + 8 bits + stop.
//     tx_out = 0,1,0,1,0,1,0,1,0,1 for 16 clks each; frame_done at clk 160 after start.
//  2. 8E2, 0xA5 -> parity bit 0. Then 8O2 -> parity bit 1. Two 16-clk stop bits.
//  3. 5-bit odd parity, tx_data=0xFF -> data 11111, parity 0.
//     cfg_data_bits=3 -> clamped to 5, same waveform.
//  4. OS13, div=3 -> every bit lasts 39 clks. div=0 -> each bit lasts 13 clks.
//  5. tx_valid held high, two words -> exactly 1 idle-high clk between frames; tx_ready high only that clk.
//  6. rst_n low mid-DATA -> tx_out=1 next edge, no frame_done.
//     With UART_TX_PARITY_ERR_INJ_EN, inj=1 on test 2 even -> parity bit 1.

Source files
------------

// File: rtl/uart_param_tx.sv
// Runtime-configurable UART transmitter: start, 5..MAX_DATA_WIDTH data bits (LSB first),
// optional parity, 1/2 stop bits, 16x/13x oversampling. Optional UART_TX_PARITY_ERR_INJ_EN adds cfg_parity_inj.
module uart_param_tx #(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int DIV_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                cfg_data_bits,
  input  logic                      cfg_parity_en,
  input  logic                      cfg_parity_odd,
  input  logic                      cfg_two_stop,
  input  logic                      cfg_os13,
  input  logic [DIV_WIDTH-1:0]      cfg_baud_div,
`ifdef UART_TX_PARITY_ERR_INJ_EN
  input  logic                      cfg_parity_inj,
`endif
  input  logic                      tx_valid,
  input  logic [MAX_DATA_WIDTH-1:0] tx_data,
  output logic                      tx_ready,
  output logic                      tx_out,
  output logic                      tx_busy,
  output logic                      frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [3:0] OS16_LAST = 4'd15;
  localparam logic [3:0] OS13_LAST = 4'd12;

  state_e                    state_q, state_d;
  logic [DIV_WIDTH-1:0]      tick_q, tick_d;
  logic [3:0]                os_q, os_d;
  logic [3:0]                bits_left_q, bits_left_d;
  logic                      stop_left_q, stop_left_d;
  logic [MAX_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                      parity_q, parity_d;
  logic                      par_en_q, par_en_d;
  logic                      os13_q, os13_d;
  logic [DIV_WIDTH-1:0]      div_m1_q, div_m1_d;

  logic                      inj;
  logic                      accept;
  logic                      tick_wrap;
  logic                      os_wrap;
  logic                      bit_end;
  logic [3:0]                nbits;
  logic [MAX_DATA_WIDTH-1:0] used_data;

`ifdef UART_TX_PARITY_ERR_INJ_EN
  assign inj = cfg_parity_inj;
`else
  assign inj = 1'b0;
`endif

  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    if (b < 4'd5)
      return 4'd5;
    if (int'(b) > MAX_DATA_WIDTH)
      return 4'(MAX_DATA_WIDTH);
    return b;
  endfunction

  assign nbits     = clamp_bits(cfg_data_bits);
  assign tx_ready  = rst_n && (state_q == IDLE);
  assign accept    = tx_valid && tx_ready;
  assign tx_busy   = (state_q != IDLE);
  assign tick_wrap = (tick_q == div_m1_q);
  assign os_wrap   = (os_q == (os13_q ? OS13_LAST : OS16_LAST));
  assign bit_end   = tx_busy && tick_wrap && os_wrap;
  // Reset is gated in so an aborted frame never reports completion.
  assign frame_done = rst_n && (state_q == STOP) && bit_end && !stop_left_q;

  always_comb begin
    used_data = '0;
    for (int i = 0; i < MAX_DATA_WIDTH; i++)
      used_data[i] = tx_data[i] && (i < int'(nbits));
  end

  always_comb begin
    tx_out = 1'b1;
    case (state_q)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift_q[0];
      PARITY:  tx_out = parity_q;
      default: tx_out = 1'b1;
    endcase
  end

  // NOTE: every _d gets its _q value first so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    os_d        = os_q;
    bits_left_d = bits_left_q;
    stop_left_d = stop_left_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    par_en_d    = par_en_q;
    os13_d      = os13_q;
    div_m1_d    = div_m1_q;

    if (tx_busy) begin
      if (tick_wrap) begin
        tick_d = '0;
        os_d   = os_wrap ? 4'd0 : os_q + 4'd1;
      end else begin
        tick_d = tick_q + DIV_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = START;
          tick_d      = '0;
          os_d        = '0;
          bits_left_d = nbits - 4'd1;
          stop_left_d = cfg_two_stop;
          shift_d     = used_data;
          parity_d    = (^used_data) ^ cfg_parity_odd ^ inj;
          par_en_d    = cfg_parity_en;
          os13_d      = cfg_os13;
          // A divisor of zero behaves as one clk per oversample tick.
          div_m1_d    = (cfg_baud_div == '0) ? '0 : cfg_baud_div - DIV_WIDTH'(1);
        end
      end
      START: begin
        if (bit_end)
          state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bits_left_q == 4'd0) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bits_left_d = bits_left_q - 4'd1;
            shift_d     = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end)
          state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop_left_q)
            stop_left_d = 1'b0;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the control state so the
  // block is fully deterministic out of reset; they are few and cheap to clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      os_q        <= '0;
      bits_left_q <= '0;
      stop_left_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      par_en_q    <= 1'b0;
      os13_q      <= 1'b0;
      div_m1_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update parallel at the edge.
      state_q     <= state_d;
      tick_q      <= tick_d;
      os_q        <= os_d;
      bits_left_q <= bits_left_d;
      stop_left_q <= stop_left_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      par_en_q    <= par_en_d;
      os13_q      <= os13_d;
      div_m1_q    <= div_m1_d;
    end
  end

endmodule

// File: tb/tb_uart_param_tx.sv
// Self-checking bench for uart_param_tx: a per-cycle line-level model built from frame rules,
// compared every cycle, plus literal frame-length and bit-sample expectations.
module tb_uart_param_tx;

  localparam int W  = 8;
  localparam int DW = 16;
`ifdef UART_TX_PARITY_ERR_INJ_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    cfg_data_bits = 4'd8;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_odd = 1'b0;
  logic          cfg_two_stop = 1'b0;
  logic          cfg_os13 = 1'b0;
  logic [DW-1:0] cfg_baud_div = 16'd1;
  logic          cfg_parity_inj = 1'b0;
  logic          tx_valid = 1'b0;
  logic [W-1:0]  tx_data = '0;
  logic          tx_ready, tx_out, tx_busy, frame_done;

  int checks = 0;
  int errors = 0;

  uart_param_tx #(.MAX_DATA_WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_two_stop   (cfg_two_stop),
    .cfg_os13       (cfg_os13),
    .cfg_baud_div   (cfg_baud_div),
`ifdef UART_TX_PARITY_ERR_INJ_EN
    .cfg_parity_inj (cfg_parity_inj),
`endif
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .tx_out         (tx_out),
    .tx_busy        (tx_busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected line level for every remaining clk of the current frame.
  logic exp_q[$];
  bit   model_on = 1'b0;

  task automatic model_push();
    int   n, len, div_eff;
    logic p;
    logic frame[$];
    n       = (cfg_data_bits < 5) ? 5 : ((int'(cfg_data_bits) > W) ? W : int'(cfg_data_bits));
    div_eff = (cfg_baud_div == 0) ? 1 : int'(cfg_baud_div);
    len     = div_eff * (cfg_os13 ? 13 : 16);
    p       = 1'b0;
    frame.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      frame.push_back(tx_data[i]);
      p = p ^ tx_data[i];
    end
    if (cfg_parity_en)
      frame.push_back(p ^ cfg_parity_odd ^ (INJ_EN & cfg_parity_inj));
    frame.push_back(1'b1);
    if (cfg_two_stop)
      frame.push_back(1'b1);
    foreach (frame[b])
      for (int c = 0; c < len; c++)
        exp_q.push_back(frame[b]);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_on = 1'b1;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else if (tx_valid && model_on) begin
      model_push();
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      if (exp_q.size() > 0) begin
        check("tx_out",     tx_out,     exp_q[0]);
        check("tx_busy",    tx_busy,    1);
        check("tx_ready",   tx_ready,   0);
        check("frame_done", frame_done, (exp_q.size() == 1) && rst_n);
      end else begin
        check("tx_out",     tx_out,     1);
        check("tx_busy",    tx_busy,    0);
        check("tx_ready",   tx_ready,   rst_n);
        check("frame_done", frame_done, 0);
      end
    end
  end

  task automatic set_cfg(input int bits, input bit pen, input bit podd, input bit two,
                         input bit os13, input int div);
    cfg_data_bits  = 4'(bits);
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    cfg_two_stop   = two;
    cfg_os13       = os13;
    cfg_baud_div   = DW'(div);
  endtask

  task automatic send(input logic [W-1:0] d);
    int k;
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx_ready !== 1'b1 && k < 2000);
    if (k >= 2000) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  // Measures frame length from first start clk to frame_done inclusive; samples mid-bit levels.
  task automatic capture(input int bit_len, output int len, output logic [15:0] s);
    int k;
    bit done;
    s = '0;
    len = 0;
    done = 1'b0;
    @(negedge clk);
    k = 0;
    while (!(tx_busy === 1'b1 && tx_out === 1'b0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      check("start_timeout", 0, 1);
      return;
    end
    k = 0;
    while (!done && k < 5000) begin
      if ((k % bit_len) == bit_len / 2 && (k / bit_len) < 16)
        s[k / bit_len] = tx_out;
      if (frame_done === 1'b1) begin
        done = 1'b1;
        len = k + 1;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 5000);
    if (k >= 5000) check(name, 0, 1);
  endtask

  initial begin
    int          len, n;
    logic [15:0] s;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_out", tx_out, 1);
    check("rst_busy",   tx_busy, 0);
    check("rst_ready",  tx_ready, 0);
    check("rst_done",   frame_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", tx_ready, 1);

    // 8N1, OS16, div=1, 0x55
    set_cfg(8, 0, 0, 0, 0, 1);
    send(8'h55);
    capture(16, len, s);
    check("t1_len", len, 160);
    check("t1_bits", 32'(s), 32'h2AA);

    // 8E2 and 8O2, 0xA5
    set_cfg(8, 1, 0, 1, 0, 1);
    send(8'hA5);
    capture(16, len, s);
    check("t2e_len", len, 192);
    check("t2e_bits", 32'(s), 32'hD4A);
    set_cfg(8, 1, 1, 1, 0, 1);
    send(8'hA5);
    capture(16, len, s);
    check("t2o_len", len, 192);
    check("t2o_par", 32'(s[9]), 1);

    // 5-bit odd parity with 0xFF; config/data changes after accept must not matter
    set_cfg(5, 1, 1, 0, 0, 1);
    send(8'hFF);
    tx_data = 8'h00;
    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    capture(16, len, s);
    check("t3_len", len, 128);
    check("t3_bits", 32'(s), 32'hBE);
    set_cfg(3, 1, 1, 0, 0, 1);
    send(8'hFF);
    capture(16, len, s);
    check("t3c_len", len, 128);
    check("t3c_bits", 32'(s), 32'hBE);

    // OS13 with div=3 and div=0
    set_cfg(8, 0, 0, 0, 1, 3);
    send(8'h55);
    capture(39, len, s);
    check("t4a_len", len, 390);
    check("t4a_bits", 32'(s), 32'h2AA);
    set_cfg(8, 0, 0, 0, 1, 0);
    send(8'h55);
    capture(13, len, s);
    check("t4b_len", len, 130);
    check("t4b_bits", 32'(s), 32'h2AA);

    // Back-to-back with tx_valid held high
    set_cfg(8, 1, 0, 0, 0, 1);
    @(posedge clk); #1;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy !== 1'b1 && n < 100);
    @(posedge clk); #1 tx_data = 8'hC7;
    wait_done("t5_done1_timeout");
    n = 0;
    @(negedge clk);
    while (tx_busy !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("t5_idle_clks", n, 1);
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_done("t5_done2_timeout");

    // Reset mid-DATA aborts the frame
    set_cfg(8, 0, 0, 0, 0, 1);
    send(8'h0F);
    repeat (50) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_line_high", tx_out, 1);
    check("t6_not_busy", tx_busy, 0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) n++;
    end
    check("t6_no_done", n, 0);

    if (INJ_EN) begin
      set_cfg(8, 1, 0, 1, 0, 1);
      cfg_parity_inj = 1'b1;
      send(8'hA5);
      cfg_parity_inj = 1'b0;
      capture(16, len, s);
      check("inj_par", 32'(s[9]), 1);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
